bitty_alu: RTL and testbench



---
 rtl/bitty_pkg.sv | 21 ++
 rtl/bitty_shifter.sv | 29 ++
 rtl/bitty_alu.sv | 107 ++++++++++
 tb/tb_bitty_alu.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bitty_pkg.sv
// rtl/bitty_pkg.sv - shared opcode encoding and constants for the Bitty ALU
package bitty_pkg;

    localparam int BITTY_W = 16;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        SHL = 3'd5,
        SHR = 3'd6,
        CMP = 3'd7
    } alu_op_e;

    localparam int CMP_EQ = 0;
    localparam int CMP_GT = 1;
    localparam int CMP_LT = 2;

endpackage

// File: rtl/bitty_shifter.sv
// rtl/bitty_shifter.sv - logical left/right shifter that yields 0 for shift amounts >= WIDTH
module bitty_shifter #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] shl_out,
    output logic [WIDTH-1:0] shr_out
);

    localparam int SW = $clog2(WIDTH);

    logic             too_far;
    logic [SW-1:0]    amt;

    // Any bit at or above position SW means the whole operand shifts out.
    assign too_far = |(in_b >> SW);
    assign amt     = in_b[SW-1:0];

    always_comb begin
        shl_out = '0;
        shr_out = '0;
        if (!too_far) begin
            shl_out = in_a << amt;
            shr_out = in_a >> amt;
        end
    end

endmodule

// File: rtl/bitty_alu.sv
// rtl/bitty_alu.sv - 16-bit Bitty ALU with registered result; BITTY_ALU_FLAGS_EN adds status flags
module bitty_alu
    import bitty_pkg::*;
#(
    parameter int WIDTH = BITTY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       select,
    input  logic             en,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_out_q
`ifdef BITTY_ALU_FLAGS_EN
    ,
    output logic [3:0]       flags,
    output logic [3:0]       flags_q
`endif
);

    logic [WIDTH-1:0] shl_out;
    logic [WIDTH-1:0] shr_out;
    logic [WIDTH-1:0] alu_out_q_d;

    bitty_shifter #(.WIDTH(WIDTH)) u_shifter (
        .in_a    (in_a),
        .in_b    (in_b),
        .shl_out (shl_out),
        .shr_out (shr_out)
    );

    always_comb begin
        alu_out = '0;
        case (alu_op_e'(select))
            ADD:     alu_out = in_a + in_b;
            SUB:     alu_out = in_a - in_b;
            AND:     alu_out = in_a & in_b;
            OR:      alu_out = in_a | in_b;
            XOR:     alu_out = in_a ^ in_b;
            SHL:     alu_out = shl_out;
            SHR:     alu_out = shr_out;
            CMP: begin
                if (in_a == in_b)     alu_out = WIDTH'(CMP_EQ);
                else if (in_a > in_b) alu_out = WIDTH'(CMP_GT);
                else                  alu_out = WIDTH'(CMP_LT);
            end
            default: alu_out = '0;
        endcase
    end

    assign alu_out_q_d = en ? alu_out : alu_out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_out_q <= '0;
        end else begin
            alu_out_q <= alu_out_q_d;
        end
    end

`ifdef BITTY_ALU_FLAGS_EN
    logic [WIDTH:0] add_full;
    logic           carry;
    logic           overflow;
    logic [3:0]     flags_q_d;
    logic           msb_a;
    logic           msb_b;
    logic           msb_r;

    assign add_full = {1'b0, in_a} + {1'b0, in_b};
    assign msb_a    = in_a[WIDTH-1];
    assign msb_b    = in_b[WIDTH-1];
    assign msb_r    = alu_out[WIDTH-1];

    always_comb begin
        carry    = 1'b0;
        overflow = 1'b0;
        case (alu_op_e'(select))
            ADD: begin
                carry    = add_full[WIDTH];
                overflow = (msb_a == msb_b) && (msb_r != msb_a);
            end
            SUB: begin
                carry    = in_a < in_b;
                overflow = (msb_a != msb_b) && (msb_r != msb_a);
            end
            default: begin
                carry    = 1'b0;
                overflow = 1'b0;
            end
        endcase
    end

    assign flags     = {carry, (alu_out == '0), msb_r, overflow};
    assign flags_q_d = en ? flags : flags_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_q_d;
        end
    end
`endif

endmodule

// File: tb/tb_bitty_alu.sv
// tb/tb_bitty_alu.sv - randomized and directed self-checking bench for bitty_alu
module tb_bitty_alu;

    logic        clk;
    logic        reset;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [2:0]  select;
    logic        en;
    logic [15:0] alu_out;
    logic [15:0] alu_out_q;
`ifdef BITTY_ALU_FLAGS_EN
    logic [3:0]  flags;
    logic [3:0]  flags_q;
    logic [3:0]  exp_flags_q;
`endif

    int          n_cmp;
    int          n_err;
    logic [15:0] exp_q;

    bitty_alu #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_a      (in_a),
        .in_b      (in_b),
        .select    (select),
        .en        (en),
        .alu_out   (alu_out),
        .alu_out_q (alu_out_q)
`ifdef BITTY_ALU_FLAGS_EN
        ,
        .flags     (flags),
        .flags_q   (flags_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_alu(input int unsigned a, input int unsigned b, input int op);
        int unsigned r;
        case (op)
            0: r = (a + b) % 65536;
            1: r = (a + 65536 - b) % 65536;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (b >= 16) ? 0 : ((a * (1 << b)) % 65536);
            6: r = (b >= 16) ? 0 : (a / (1 << b));
            default: r = (a == b) ? 0 : ((a > b) ? 1 : 2);
        endcase
        return r[15:0];
    endfunction

    function automatic logic [3:0] ref_flags(input int unsigned a, input int unsigned b, input int op);
        int          sa;
        int          sb;
        int          s;
        logic [15:0] r;
        logic        c;
        logic        v;
        sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
        sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
        r  = ref_alu(a, b, op);
        c  = 1'b0;
        v  = 1'b0;
        if (op == 0) begin
            c = (a + b) > 65535;
            s = sa + sb;
            v = (s > 32767) || (s < -32768);
        end else if (op == 1) begin
            c = a < b;
            s = sa - sb;
            v = (s > 32767) || (s < -32768);
        end
        return {c, (r == 16'h0), r[15], v};
    endfunction

    // Drive at negedge, check the combinational result, then the register after the next posedge.
    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s,
                         input logic e, input string tag);
        @(negedge clk);
        in_a   = a;
        in_b   = b;
        select = s;
        en     = e;
        #1;
        check({tag, "_out"}, {16'h0, alu_out}, {16'h0, ref_alu(a, b, s)});
`ifdef BITTY_ALU_FLAGS_EN
        check({tag, "_flags"}, {28'h0, flags}, {28'h0, ref_flags(a, b, s)});
        if (e) exp_flags_q = ref_flags(a, b, s);
`endif
        if (e) exp_q = ref_alu(a, b, s);
        @(posedge clk);
        #1;
        check({tag, "_q"}, {16'h0, alu_out_q}, {16'h0, exp_q});
`ifdef BITTY_ALU_FLAGS_EN
        check({tag, "_flags_q"}, {28'h0, flags_q}, {28'h0, exp_flags_q});
`endif
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        n_cmp  = 0;
        n_err  = 0;
        exp_q  = 16'h0;
`ifdef BITTY_ALU_FLAGS_EN
        exp_flags_q = 4'h0;
`endif
        reset  = 1'b1;
        in_a   = 16'h1234;
        in_b   = 16'h0001;
        select = 3'd0;
        en     = 1'b1;
        #1;
        check("reset_q", {16'h0, alu_out_q}, 32'h0);
        @(posedge clk);
        #1;
        check("reset_hold_q", {16'h0, alu_out_q}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        apply(16'hFFFF, 16'h0002, 3'd0, 1'b1, "add_wrap");
        apply(16'h0003, 16'h0005, 3'd1, 1'b1, "sub_under");
        apply(16'h0F0F, 16'h00FF, 3'd2, 1'b1, "and");
        apply(16'h0F0F, 16'h00FF, 3'd3, 1'b1, "or");
        apply(16'h0F0F, 16'h00FF, 3'd4, 1'b1, "xor");
        apply(16'h0001, 16'h0004, 3'd5, 1'b1, "shl4");
        apply(16'h8000, 16'h000F, 3'd6, 1'b1, "shr15");
        apply(16'hFFFF, 16'h0010, 3'd5, 1'b1, "shl16");
        apply(16'hFFFF, 16'h0010, 3'd6, 1'b1, "shr16");
        apply(16'hFFFF, 16'h0100, 3'd5, 1'b1, "shl256");
        apply(16'h0007, 16'h0007, 3'd7, 1'b1, "cmp_eq");
        apply(16'h0009, 16'h0007, 3'd7, 1'b1, "cmp_gt");
        apply(16'h0007, 16'h0009, 3'd7, 1'b1, "cmp_lt");
        apply(16'h8000, 16'h0001, 3'd7, 1'b1, "cmp_uns");
        apply(16'h7FFF, 16'h0001, 3'd0, 1'b1, "add_ovf");
        apply(16'hFFFF, 16'h0001, 3'd0, 1'b1, "add_carry");
        apply(16'h1111, 16'h2222, 3'd0, 1'b0, "hold1");
        apply(16'hAAAA, 16'h5555, 3'd4, 1'b0, "hold2");

        // Asynchronous reset mid-cycle, held across an edge, then released with en=1.
        apply(16'h0100, 16'h0023, 3'd0, 1'b1, "pre_rst");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_q", {16'h0, alu_out_q}, 32'h0);
        exp_q = 16'h0;
`ifdef BITTY_ALU_FLAGS_EN
        check("async_rst_flags_q", {28'h0, flags_q}, 32'h0);
        exp_flags_q = 4'h0;
`endif
        @(posedge clk);
        #1;
        check("rst_prio_q", {16'h0, alu_out_q}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        apply(16'h0042, 16'h0001, 3'd1, 1'b1, "post_rst");

        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            apply(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
